// File: rtl/audio_ctrl_pkg.sv
// audio_ctrl_pkg: shared select-code constants and types for the audio controller
package audio_ctrl_pkg;
    localparam int N_IN_DEF  = 3;
    localparam int W_OUT_DEF = $clog2(N_IN_DEF + 1);
    typedef logic [W_OUT_DEF-1:0] sel_code_t;
endpackage

// File: rtl/onehot_popcount.sv
// onehot_popcount: flags a vector with two or more bits set, or with none set
module onehot_popcount #(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0] data,
    output logic            multi,
    output logic            none
);
    logic any;
    // Running "seen one already" term; a second set bit raises multi
    always_comb begin
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            multi = multi | (any & data[i]);
            any   = any | data[i];
        end
        none = ~any;
    end
endmodule

// File: rtl/onehot_encoder.sv
// onehot_encoder: one-hot select to binary code (0 = none, i+1 = bit i), highest set bit wins
module onehot_encoder
    import audio_ctrl_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int W_OUT = $clog2(N_IN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  data,
    output logic [W_OUT-1:0] q,
    output logic [W_OUT-1:0] q_reg,
    output logic             multi_hot,
    output logic             multi_hot_sticky,
    output logic             none_hot
);
    logic multi, none;
    // Ternary rather than if so an X data bit propagates into q instead of reading as 0
    always_comb begin
        q = '0;
        for (int i = 0; i < N_IN; i++)
            q = data[i] ? W_OUT'(i + 1) : q;
    end
    onehot_popcount #(.N_IN(N_IN)) u_pop (
        .data  (data),
        .multi (multi),
        .none  (none)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg            <= '0;
            multi_hot        <= 1'b0;
            multi_hot_sticky <= 1'b0;
            none_hot         <= 1'b1;
        end else begin
            q_reg            <= q;
            multi_hot        <= multi;
            multi_hot_sticky <= multi_hot_sticky | multi;
            none_hot         <= none;
        end
    end
endmodule

// File: tb/tb_onehot_encoder.sv
// tb_onehot_encoder: scoreboard bench for onehot_encoder with N_IN = 3
module tb_onehot_encoder;
    import audio_ctrl_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] data = 3'b000;
    sel_code_t  q, q_reg;
    logic       multi_hot, multi_hot_sticky, none_hot;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb[$];
    logic       sticky_m = 1'b0;

    onehot_encoder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data             (data),
        .q                (q),
        .q_reg            (q_reg),
        .multi_hot        (multi_hot),
        .multi_hot_sticky (multi_hot_sticky),
        .none_hot         (none_hot)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_q(input logic [2:0] d);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 3; i++)
            if (d[i]) r = 2'(i + 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, check q combinationally, then check the registered view after the rising edge
    task automatic drive(input logic [2:0] d);
        logic [3:0] e;
        @(negedge clk);
        data = d;
        #1;
        chk("q", 32'(q), 32'(ref_q(d)));
        sb.push_back({ref_q(d), ($countones(d) >= 2) ? 1'b1 : 1'b0, (d == 3'b000) ? 1'b1 : 1'b0});
        @(posedge clk);
        sticky_m = sticky_m | ($countones(d) >= 2);
        #1;
        e = sb.pop_front();
        chk("q_reg", 32'(q_reg), 32'(e[3:2]));
        chk("multi_hot", 32'(multi_hot), 32'(e[1]));
        chk("none_hot", 32'(none_hot), 32'(e[0]));
        chk("sticky", 32'(multi_hot_sticky), 32'(sticky_m));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_q_reg"}, 32'(q_reg), 32'd0);
        chk({tag, "_multi"}, 32'(multi_hot), 32'd0);
        chk({tag, "_sticky"}, 32'(multi_hot_sticky), 32'd0);
        chk({tag, "_none"}, 32'(none_hot), 32'd1);
        chk({tag, "_q_live"}, 32'(q), 32'(ref_q(data)));
    endtask

    initial begin
        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b000);
        drive(3'b001);
        drive(3'b010);
        drive(3'b100);
        // Asynchronous reset in the middle of the high phase
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sticky_m = 1'b0;
        check_reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b011);
        drive(3'b111);
        drive(3'b001);
        drive(3'b000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sticky_m = 1'b0;
        check_reset_vals("clr");
        // Multi-hot present at the first edge after reset release
        data = 3'b110;
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b110);
        for (int v = 0; v < 8; v++)
            drive(3'(v));
        for (int k = 0; k < 20; k++)
            drive(3'($urandom_range(0, 7)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/onehot_encoder.md
# onehot_encoder

Converts a one-hot select vector into a compact binary code, with zero meaning "nothing selected". It sits in the Audio Controller between one-hot source/mode select lines and the logic that consumes a binary index. The primary output `q` is combinational. A registered copy and error-status flags are provided for synchronous consumers.

## Interface
Parameters:
- `N_IN`, default 3: width of the one-hot input. Must be ≥ 1.
- `W_OUT`, default `$clog2(N_IN+1)` (2 for `N_IN`=3): code width. Must be able to hold the value `N_IN`.

Ports:
- `clk`  in  1: single clock for all registered outputs.
- `rst_n`  in  1: reset, asynchronous, active-low. Clears all registered outputs.
- `data`  in  `N_IN`: one-hot select vector. All-zero means no selection.
- `q`  out  `W_OUT`: combinational code. 0 when nothing is selected, i+1 when bit i is selected.
- `q_reg`  out  `W_OUT`: `q` registered on `clk`.
- `multi_hot`  out  1: registered flag, 1 when `data` had more than one bit set on the last clock edge.
- `multi_hot_sticky`  out  1: set on any multi-hot sample; cleared only by reset.
- `none_hot`  out  1: registered flag, 1 when `data` was all-zero on the last clock edge.

## Operation
- Encoding of `q`:
  - `data` == 0 gives `q` = 0.
  - A single set bit i (LSB is i=0) gives `q` = i+1.
  - For `N_IN`=3: 000→0, 001→1, 010→2, 100→3.
- Multi-hot input is resolved by priority: the highest set index wins. Example: 011→2, 111→3.
- Multi-hot detection: `multi_hot` is 1 when the population count of `data` is ≥ 2.
- `multi_hot_sticky` latches to 1 on the first edge where the multi-hot condition holds and stays 1 until `rst_n` is asserted.
- X or Z on any `data` bit must not be silently masked. `q` is allowed to go X in simulation.

## Timing
- `q`: purely combinational, zero latency. It is valid within the same delta/settle time as `data`, and it is not affected by `clk` or `rst_n`.
- `q_reg`, `multi_hot`, `none_hot`: one-cycle latency. Each updates on the rising edge of `clk` from the value of `data` at that edge.
- Reset values while `rst_n` = 0:
  - `q_reg` = 0
  - `multi_hot` = 0
  - `multi_hot_sticky` = 0
  - `none_hot` = 1
- Reset takes effect immediately, with no clock required. The first capture happens on the first rising edge after `rst_n` deasserts.
- If reset is asserted mid-operation, registered outputs return to their reset values at once; `q` keeps tracking `data`.
- If the multi-hot condition and reset deassertion coincide on the same edge, the multi-hot sample is captured normally.

## Structure
- Shared package `audio_ctrl_pkg`:
  - default `N_IN` and `W_OUT` constants
  - a `sel_code_t` typedef, `logic [W_OUT-1:0]`
- A single sub-module, `onehot_popcount`, returns "≥2 bits set" and "zero bits set" for a `N_IN`-wide vector. It is used for the status flags.
- The priority encoder itself is a for-loop in `always_comb`, ascending index, so the last set bit wins.

## Test plan
1. `data`=000, wait 10 ns → `q`=0. After one clock edge: `q_reg`=0, `none_hot`=1.
2. Walk `data` through 001, 010, 100, holding each for 10 ns → `q`=1, 2, 3 in turn. `q_reg` follows one edge later; `multi_hot` stays 0.
3. Apply reset: `rst_n`=0 mid-clock-period → `q_reg`=0, `none_hot`=1 and `multi_hot_sticky`=0 immediately, while `q` still matches `data`.
4. `data`=011, then 111 → `q`=2, then 3. `multi_hot`=1 after the edge, and `multi_hot_sticky`=1.
5. Return `data` to 001 after step 4 → `q`=1 and `multi_hot`=0 after the next edge. `multi_hot_sticky` stays 1 until `rst_n` pulses low.
6. Exhaustive: for all 8 `data` values, check `q` against the reference priority model and `multi_hot` against the popcount.
